// File: rtl/qspi_mem_arbiter.sv
// qspi_mem_arbiter: shares one QSPI controller between an instruction-fetch
// port and a data port. Data normally wins. A bounded starvation counter
// forces an instruction grant after STARVE_LIMIT data grants in a row while
// an instruction fetch is waiting. Writes aimed at flash are refused locally
// with an error response, and the controller is never started for them.
// All outputs are registered; reset is synchronous and active-low.
module qspi_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [24:0] i_addr,
  output logic        i_gnt,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [24:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] rdata,
  output logic        m_start,
  output logic        m_we,
  output logic [23:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_sel,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;   // 1'b1 = data port owns the transaction
  logic [CW-1:0] starve, starve_nx;
  logic          pick_d, grant_i, grant_d;
  logic          i_gnt_nx, i_done_nx, d_gnt_nx, d_done_nx, d_err_nx;
  logic          m_start_nx, m_we_nx;
  logic [23:0]   m_addr_nx;
  logic [31:0]   m_wdata_nx, rdata_nx;
  logic [1:0]    m_sel_nx;

  // Next-state, arbitration, starvation counter and next registered outputs
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    starve_nx  = starve;
    rdata_nx   = rdata;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_gnt_nx   = 1'b0;
    i_done_nx  = 1'b0;
    d_gnt_nx   = 1'b0;
    d_done_nx  = 1'b0;
    d_err_nx   = 1'b0;
    m_start_nx = 1'b0;
    m_we_nx    = 1'b0;
    m_addr_nx  = 24'h000000;
    m_wdata_nx = 32'h00000000;
    m_sel_nx   = 2'b00;
    pick_d     = d_req && !(i_req && (starve == LIMIT));

    case (state)
      IDLE: begin
        if (!m_busy && (i_req || d_req)) begin
          if (pick_d) begin
            grant_d  = 1'b1;
            owner_nx = 1'b1;
            d_gnt_nx = 1'b1;
            if (d_we && !d_addr[24]) begin
              // flash is read-only: refuse without touching the controller
              state_nx  = RESP;
              d_done_nx = 1'b1;
              d_err_nx  = 1'b1;
            end else begin
              state_nx   = START;
              m_start_nx = 1'b1;
              m_we_nx    = d_we;
              m_addr_nx  = d_addr[23:0];
              m_wdata_nx = d_wdata;
              m_sel_nx   = d_addr[24] ? 2'b10 : 2'b01;
            end
          end else begin
            grant_i    = 1'b1;
            owner_nx   = 1'b0;
            i_gnt_nx   = 1'b1;
            state_nx   = START;
            m_start_nx = 1'b1;
            m_addr_nx  = i_addr[23:0];
            m_sel_nx   = i_addr[24] ? 2'b10 : 2'b01;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (m_done) begin
          rdata_nx  = m_rdata;
          state_nx  = RESP;
          i_done_nx = !owner;
          d_done_nx = owner;
        end else begin
          state_nx = WAIT;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (!i_req) begin
      starve_nx = {CW{1'b0}};
    end else if (grant_i) begin
      starve_nx = {CW{1'b0}};
    end else if (grant_d && (starve != LIMIT)) begin
      starve_nx = starve + CW'(1);
    end else begin
      starve_nx = starve;
    end
  end

  // State, owner, starvation count and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      starve  <= {CW{1'b0}};
      i_gnt   <= 1'b0;
      i_done  <= 1'b0;
      d_gnt   <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      m_start <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 24'h000000;
      m_wdata <= 32'h00000000;
      m_sel   <= 2'b00;
      rdata   <= 32'h00000000;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      starve  <= starve_nx;
      i_gnt   <= i_gnt_nx;
      i_done  <= i_done_nx;
      d_gnt   <= d_gnt_nx;
      d_done  <= d_done_nx;
      d_err   <= d_err_nx;
      m_start <= m_start_nx;
      m_we    <= m_we_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      m_sel   <= m_sel_nx;
      rdata   <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Bench for qspi_mem_arbiter: a transaction-level reference model predicts
// every cycle's handshake/command outputs, a compare process checks them on
// each falling edge, and directed scenarios add hand-computed expectations.
module tb_qspi_mem_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, m_busy;
  logic [24:0] i_addr, d_addr;
  logic [31:0] d_wdata, m_rdata;
  logic        i_gnt, i_done, d_gnt, d_done, d_err, m_start, m_we;
  logic [31:0] rdata, m_wdata;
  logic [23:0] m_addr;
  logic [1:0]  m_sel;
  logic        m_done, rsp_done, spur_done;
  int          rsp_cnt, rsp_lat;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gnt_count = 0, done_count = 0, start_count = 0;
  byte dut_log[$];
  byte model_log[$];

  typedef struct packed {
    logic        i_gnt, d_gnt, i_done, d_done, d_err, m_start, m_we;
    logic [1:0]  m_sel;
    logic [23:0] m_addr;
    logic [31:0] m_wdata;
  } obs_t;

  obs_t        e;
  logic [31:0] e_rdata;
  bit          rd_check, started = 1'b0;

  always #5 clk = ~clk;

  assign m_done = rsp_done | spur_done;

  qspi_mem_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .rdata(rdata),
    .m_start(m_start), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_sel(m_sel), .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata)
  );

  // QSPI controller stand-in: m_done rsp_lat falling edges after m_start
  always @(negedge clk) begin
    rsp_done = 1'b0;
    if (!rst_n) rsp_cnt = 0;
    else if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) rsp_done = 1'b1;
    end else if (m_start) rsp_cnt = rsp_lat;
  end

  // Reference model: one transaction at a time, outputs predicted per cycle
  bit m_active = 0, m_waiting = 0, m_owner_d = 0, m_owner_we = 0;
  int m_cnt = 0;
  always @(posedge clk) begin
    obs_t n;
    bit gi, gd, data_turn;
    n = '0; gi = 0; gd = 0;
    cyc = cyc + 1;
    started = 1'b1;
    if (!rst_n) begin
      m_active = 0; m_waiting = 0; m_cnt = 0;
      e_rdata = 32'h0; rd_check = 1'b1;
    end else begin
      rd_check = 1'b0;
      if (e.m_start) m_waiting = 1;          // controller just got its command
      else if (m_waiting && m_done) begin
        m_waiting = 0; m_active = 0;
        if (m_owner_d) n.d_done = 1; else n.i_done = 1;
        if (!m_owner_we) begin e_rdata = m_rdata; rd_check = 1'b1; end
      end else if (!m_active && !(e.i_done || e.d_done) && !m_busy && (i_req || d_req)) begin
        data_turn = d_req && !(i_req && m_cnt == L);
        if (data_turn) begin
          gd = 1; n.d_gnt = 1; model_log.push_back("D");
          if (d_we && !d_addr[24]) begin
            n.d_done = 1; n.d_err = 1;
          end else begin
            m_active = 1; m_owner_d = 1; m_owner_we = d_we;
            n.m_start = 1; n.m_we = d_we; n.m_addr = d_addr[23:0];
            n.m_wdata = d_wdata; n.m_sel = d_addr[24] ? 2'b10 : 2'b01;
          end
        end else begin
          gi = 1; n.i_gnt = 1; model_log.push_back("I");
          m_active = 1; m_owner_d = 0; m_owner_we = 0;
          n.m_start = 1; n.m_addr = i_addr[23:0];
          n.m_sel = i_addr[24] ? 2'b10 : 2'b01;
        end
      end
      if (!i_req || gi) m_cnt = 0;
      else if (gd) m_cnt = (m_cnt < L) ? m_cnt + 1 : L;
    end
    e = n;
  end

  function automatic obs_t dut_obs();
    return {i_gnt, d_gnt, i_done, d_done, d_err, m_start, m_we, m_sel, m_addr, m_wdata};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_for(input int kind, input string name, output int at);
    bit hit;
    hit = 0; at = -1;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      case (kind)
        0: hit = i_gnt;
        1: hit = d_gnt;
        2: hit = i_done;
        3: hit = d_done;
        default: hit = i_gnt | d_gnt;
      endcase
      if (hit) at = cyc;
    end
    if (!hit) begin
      n_assert++; n_fail++;
      $display("FAIL timeout %s: event not seen, expected within 300 cycles", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0, t1, snap, base_d, base_m, k;
    string exp_s;
    rst_n = 0; i_req = 0; d_req = 0; d_we = 0; m_busy = 0; spur_done = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; rsp_lat = 10;

    fork
      forever begin
        @(negedge clk);
        if (started) begin
          chk("cycle_outputs", 67'(dut_obs()), 67'(e));
          if (rd_check) chk("cycle_rdata", 67'(rdata), 67'(e_rdata));
          chk("one_hot", 67'({(i_gnt & d_gnt), (i_done & d_done)}), 67'd0);
          if (i_gnt) dut_log.push_back("I");
          if (d_gnt) dut_log.push_back("D");
          gnt_count   += int'(i_gnt) + int'(d_gnt);
          done_count  += int'(i_done) + int'(d_done);
          start_count += int'(m_start);
        end
      end
    join_none

    idle(3);
    chk("reset_outputs", 67'(dut_obs()), 67'd0);
    chk("reset_rdata", 67'(rdata), 67'd0);
    rst_n = 1;

    // single instruction read from flash
    i_req = 1; i_addr = 25'h0000100; m_rdata = 32'h12345678; rsp_lat = 10;
    wait_for(0, "instr_gnt", t0);
    chk("instr_cmd", 67'({m_start, m_sel, m_addr}), 67'({1'b1, 2'b01, 24'h000100}));
    i_req = 0;
    wait_for(2, "instr_done", t1);
    chk("instr_rdata", 67'(rdata), 67'(32'h12345678));
    chk("instr_latency", 67'(t1 - t0), 67'd11);
    idle(2);

    // simultaneous requests: data first, then instruction
    i_req = 1; i_addr = 25'h0000200; d_req = 1; d_we = 0; d_addr = 25'h1000040;
    m_rdata = 32'hA5A55A5A; rsp_lat = 3;
    wait_for(4, "sim_first_gnt", t0);
    chk("sim_first_is_data", 67'({i_gnt, d_gnt, m_sel, m_addr}), 67'({1'b0, 1'b1, 2'b10, 24'h000040}));
    d_req = 0;
    wait_for(4, "sim_second_gnt", t0);
    chk("sim_second_is_instr", 67'({i_gnt, d_gnt, m_sel, m_addr}), 67'({1'b1, 1'b0, 2'b01, 24'h000200}));
    i_req = 0;
    wait_for(2, "sim_instr_done", t1);
    idle(2);

    // continuous contention: starvation limit forces every fifth grant
    base_d = dut_log.size(); base_m = model_log.size();
    i_req = 1; d_req = 1; d_we = 0; d_addr = 25'h1000000; rsp_lat = 2;
    for (k = 0; k < 600 && dut_log.size() < base_d + 10; k++) @(negedge clk);
    i_req = 0; d_req = 0;
    exp_s = "DDDDIDDDDI";
    for (int j = 0; j < 10; j++) begin
      chk("starve_order_dut", 67'((base_d + j < dut_log.size()) ? dut_log[base_d + j] : 8'd0), 67'(exp_s[j]));
      chk("starve_order_model", 67'((base_m + j < model_log.size()) ? model_log[base_m + j] : 8'd0), 67'(exp_s[j]));
    end
    idle(15);

    // write to flash is refused with an error, no controller command
    snap = start_count;
    d_req = 1; d_we = 1; d_addr = 25'h0000010; d_wdata = 32'hDEADBEEF;
    wait_for(1, "flash_wr_gnt", t0);
    chk("flash_wr_resp", 67'({d_gnt, d_done, d_err, m_start}), 67'(4'b1110));
    d_req = 0; d_we = 0;
    idle(6);
    chk("flash_wr_no_start", 67'(start_count - snap), 67'd0);

    // write to PSRAM goes through the controller
    d_req = 1; d_we = 1; d_addr = 25'h1000020; d_wdata = 32'hCAFEF00D; rsp_lat = 2;
    wait_for(1, "psram_wr_gnt", t0);
    chk("psram_wr_cmd", 67'({m_start, m_we, m_sel, m_wdata}), 67'({1'b1, 1'b1, 2'b10, 32'hCAFEF00D}));
    d_req = 0; d_we = 0;
    wait_for(3, "psram_wr_done", t1);
    chk("psram_wr_no_err", 67'(d_err), 67'd0);
    idle(2);

    // controller busy: no grants, spurious done ignored, withdrawn request lost
    snap = gnt_count; t0 = done_count;
    m_busy = 1; i_req = 1; i_addr = 25'h0000300; d_req = 1; d_addr = 25'h1000300;
    idle(2);
    d_req = 0;
    idle(2);
    spur_done = 1;
    idle(1);
    spur_done = 0;
    idle(4);
    chk("busy_no_gnt", 67'(gnt_count - snap), 67'd0);
    chk("spurious_no_done", 67'(done_count - t0), 67'd0);
    m_busy = 0; m_rdata = 32'h0BADF00D; rsp_lat = 2;
    wait_for(4, "after_busy_gnt", t0);
    chk("after_busy_is_instr", 67'({i_gnt, d_gnt, m_addr}), 67'({1'b1, 1'b0, 24'h000300}));
    i_req = 0;
    wait_for(2, "after_busy_done", t1);
    chk("after_busy_rdata", 67'(rdata), 67'(32'h0BADF00D));
    idle(2);

    // reset while waiting on the controller abandons the transaction
    i_req = 1; i_addr = 25'h0000400; rsp_lat = 10;
    wait_for(0, "rst_case_gnt", t0);
    i_req = 0;
    idle(3);
    rst_n = 0;
    idle(1);
    chk("mid_reset_outputs", 67'({dut_obs(), 32'h0} | 67'(rdata)), 67'd0);
    rst_n = 1;
    t0 = done_count;
    idle(15);
    chk("mid_reset_no_done", 67'(done_count - t0), 67'd0);
    d_req = 1; d_we = 0; d_addr = 25'h1000080; m_rdata = 32'h13579BDF; rsp_lat = 2;
    wait_for(1, "post_reset_gnt", t0);
    d_req = 0;
    wait_for(3, "post_reset_done", t1);
    chk("post_reset_rdata", 67'(rdata), 67'(32'h13579BDF));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
